pusch_gold_gen: RTL

- 3GPP TS 38.211 §5.2.1 length-31 Gold pseudo-random sequence generator c(n).
- Sits directly upstream of the scrambler and feeds it one Gold bit per consumed data bit.
- Loaded with c_init and a sequence length per codeword; runs an Nc-cycle warm-up, then presents bits under a valid/advance handshake.
- Busy and done status go to the PUSCH controller.

---
 rtl/pusch_gold_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pusch_gold_gen.sv
// pusch_gold_gen: length-31 Gold pseudo-random sequence generator c(n) for PUSCH scrambling.
//
// Loaded with c_init and a sequence length, it first shifts the two LFSRs NC times
// (warm-up). It then presents one Gold bit at a time under a valid/advance handshake.
//
// Ports:
//   CLK_PR      in   clock, rising edge
//   RST_PR      in   synchronous reset, active-high
//   EN_PR       in   enable; low freezes all state and masks GOLD_VALID / PR_DONE
//   START_PR    in   load request, honoured only in IDLE
//   C_INIT      in   31-bit x2 initial value
//   SEQ_LEN     in   number of bits to deliver (0 = immediate done)
//   ADV_IN      in   consumer took the current bit
//   Gold_OUT    out  current c(n), 0 outside RUN
//   GOLD_VALID  out  Gold_OUT is valid
//   PR_BUSY     out  state is not IDLE
//   PR_DONE     out  one-cycle pulse after the last bit is consumed
module pusch_gold_gen #(
   parameter int unsigned NC    = 1600,
   parameter int unsigned LEN_W = 16
) (
   input  logic             CLK_PR,
   input  logic             RST_PR,
   input  logic             EN_PR,
   input  logic             START_PR,
   input  logic [30:0]      C_INIT,
   input  logic [LEN_W-1:0] SEQ_LEN,
   input  logic             ADV_IN,
   output logic             Gold_OUT,
   output logic             GOLD_VALID,
   output logic             PR_BUSY,
   output logic             PR_DONE
);

   // Counter only needs to reach NC-1.
   localparam int unsigned WarmW = (NC > 1) ? $clog2(NC) : 1;

   typedef enum logic [1:0] {StIdle, StWarmup, StRun} state_e;

   state_e           r_state;
   logic [30:0]      r_x1;
   logic [30:0]      r_x2;
   logic [WarmW-1:0] r_warm_cnt;
   logic [LEN_W-1:0] r_bit_cnt;
   logic [LEN_W-1:0] r_seq_len;
   logic             r_gold;
   logic             r_done;

   logic [30:0]      w_x1_next;
   logic [30:0]      w_x2_next;
   logic             w_gold_next;
   logic             w_last_warm;
   logic             w_last_bit;

   // bit0 = x(n); the new bit30 is x(n+31).
   assign w_x1_next   = {r_x1[3] ^ r_x1[0], r_x1[30:1]};
   assign w_x2_next   = {r_x2[3] ^ r_x2[2] ^ r_x2[1] ^ r_x2[0], r_x2[30:1]};
   assign w_gold_next = w_x1_next[0] ^ w_x2_next[0];
   assign w_last_warm = (r_warm_cnt == WarmW'(NC - 1));
   assign w_last_bit  = (r_bit_cnt == r_seq_len - LEN_W'(1));

   always_ff @(posedge CLK_PR) begin
      if (RST_PR) begin
         r_state    <= StIdle;
         r_x1       <= '0;
         r_x2       <= '0;
         r_warm_cnt <= '0;
         r_bit_cnt  <= '0;
         r_seq_len  <= '0;
         r_gold     <= 1'b0;
         r_done     <= 1'b0;
      end else if (EN_PR) begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (START_PR) begin
                  if (SEQ_LEN != '0) begin
                     r_x1       <= 31'h0000_0001;
                     r_x2       <= C_INIT;
                     r_seq_len  <= SEQ_LEN;
                     r_warm_cnt <= '0;
                     r_bit_cnt  <= '0;
                     r_state    <= StWarmup;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            StWarmup: begin
               r_x1       <= w_x1_next;
               r_x2       <= w_x2_next;
               r_warm_cnt <= r_warm_cnt + WarmW'(1);
               if (w_last_warm) begin
                  // Register the first bit so Gold_OUT is valid on RUN entry.
                  r_gold    <= w_gold_next;
                  r_bit_cnt <= '0;
                  r_state   <= StRun;
               end
            end
            StRun: begin
               if (ADV_IN) begin
                  r_x1      <= w_x1_next;
                  r_x2      <= w_x2_next;
                  r_bit_cnt <= r_bit_cnt + LEN_W'(1);
                  if (w_last_bit) begin
                     r_gold  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= StIdle;
                  end else begin
                     r_gold <= w_gold_next;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign Gold_OUT   = r_gold;
   assign GOLD_VALID = (r_state == StRun) & EN_PR;
   assign PR_BUSY    = (r_state != StIdle);
   assign PR_DONE    = r_done & EN_PR;

endmodule
